// File: rtl/alu_requester.sv
// alu_requester: issues one command at a time to a combinational ALU, waits SETTLE_CYCLES, then returns a response.
// Ports:
//   clk_i/rst_i                           clock and synchronous active-high reset
//   cmd_valid_i/cmd_ready_o               command handshake
//   cmd_op_i/cmd_a_i/cmd_b_i              opcode (0..12 legal) and operands
//   alu_op_o/alu_a_o/alu_b_o/alu_result_i ALU drive and result
//   rsp_valid_o/rsp_ready_i               response handshake
//   rsp_data_o/rsp_op_o/rsp_err_o         result, echoed opcode, illegal-opcode flag
//   op_count_o/err_count_o                handshake counters, present only when ALU_REQUESTER_STATS_EN is defined
module alu_requester #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [5:0]  cmd_op_i,
  input  logic [31:0] cmd_a_i,
  input  logic [31:0] cmd_b_i,
  output logic [5:0]  alu_op_o,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  input  logic [31:0] alu_result_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic [5:0]  rsp_op_o,
  output logic        rsp_err_o
`ifdef ALU_REQUESTER_STATS_EN
  ,
  output logic [15:0] op_count_o,
  output logic [15:0] err_count_o
`endif
);
  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt;
  logic legal, accept, handshake;
  assign legal = cmd_op_i <= 6'd12;
  assign accept = cmd_valid_i && cmd_ready_o;
  assign handshake = rsp_valid_o && rsp_ready_i;
  // The opcode register is held until the next acceptance, so it doubles as the echoed opcode.
  assign rsp_op_o = alu_op_o;
  always_comb begin
    state_nxt = state;
    cmd_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready_o = !rst_i;
        state_nxt = cmd_valid_i ? (legal ? SETTLE : RESP) : IDLE;
      end
      SETTLE: state_nxt = cnt == 4'd0 ? RESP : SETTLE;
      RESP: begin
        rsp_valid_o = 1'b1;
        state_nxt = rsp_ready_i ? IDLE : RESP;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= 4'd0;
      alu_op_o <= 6'd0;
      alu_a_o <= 32'd0;
      alu_b_o <= 32'd0;
      rsp_data_o <= 32'd0;
      rsp_err_o <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        alu_op_o <= cmd_op_i;
        alu_a_o <= cmd_a_i;
        alu_b_o <= cmd_b_i;
        cnt <= 4'(SETTLE_CYCLES - 1);
        rsp_data_o <= 32'd0;
        rsp_err_o <= !legal;
      end
      if (state == SETTLE) begin
        cnt <= cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
        if (cnt == 4'd0) begin
          rsp_data_o <= alu_result_i;
          rsp_err_o <= 1'b0;
        end
      end
    end
  end
`ifdef ALU_REQUESTER_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_count_o <= 16'd0;
      err_count_o <= 16'd0;
    end else if (handshake) begin
      op_count_o <= op_count_o + 16'd1;
      err_count_o <= err_count_o + 16'(rsp_err_o);
    end
  end
`endif
endmodule
